// File: rtl/llm_refill_ctrl_pkg.sv
// Shared types and constants for the refill controller: fetch error codes,
// FSM states and the default beats-per-line.
package llm_refill_ctrl_pkg;

    localparam int CHI_ADDR_WIDTH = 48;
    localparam int LLM_FILL_BEATS = 4;

    typedef enum logic [1:0] {
        FE_OK   = 2'b00,
        FE_ECC  = 2'b01,
        FE_PROT = 2'b10,
        FE_TMO  = 2'b11
    } fill_err_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE
    } fill_state_e;

endpackage

// File: rtl/llm_sync_fifo.sv
// Single-clock FIFO with a clock enable; the head entry is visible without a pop.
// Pointer wrap relies on DEPTH being a power of two.
module llm_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A full FIFO can still take a push when the same cycle frees a slot.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (en && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/llm_refill_ctrl.sv
// Assembles in-order refill beats into cache lines, pairs each with its queued
// address, writes clean lines to the data array and reports completion.
module llm_refill_ctrl
    import llm_refill_ctrl_pkg::*;
#(
    parameter int BEAT_W     = 512,
    parameter int LINE_BEATS = LLM_FILL_BEATS,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_en,
    input  logic [CHI_ADDR_WIDTH-1:0]    alloc_addr,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [BEAT_W-1:0]            fetch_data,
    input  logic                         fetch_valid,
    input  logic [1:0]                   fetch_error,
    output logic                         fetch_ready,
    output logic [CHI_ADDR_WIDTH-1:0]    arr_wr_addr,
    output logic [BEAT_W*LINE_BEATS-1:0] arr_wr_data,
    output logic                         arr_wr_valid,
    input  logic                         arr_wr_ready,
    output logic                         fill_done_valid,
    output logic [CHI_ADDR_WIDTH-1:0]    fill_done_addr,
    output logic [1:0]                   fill_done_error,
    output logic [15:0]                  fill_cnt,
    output logic [15:0]                  fill_err_cnt
);

    localparam int CNT_W   = $clog2(LINE_BEATS);
    localparam int FIFO_CW = $clog2(TAG_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    fill_state_e                          state;
    logic        [CNT_W-1:0]              beat_cnt;
    fill_err_e                            err_acc;
    fill_err_e                            cur_err;
    logic        [LINE_BEATS-1:0][BEAT_W-1:0] line_q;

    logic [CHI_ADDR_WIDTH-1:0] fifo_head;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [FIFO_CW-1:0]        fifo_count;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_left;

    assign alloc_ready = ~fifo_full;
    assign fifo_push   = alloc_valid & alloc_ready;
    assign fifo_pop    = (state == ST_DONE);
    // Whether another address remains once this cycle's pop (and any push) lands.
    assign fifo_left   = (fifo_count > FIFO_CW'(1)) | fifo_push;
    assign arr_wr_data = line_q;

    always_comb begin
        cur_err = err_acc;
        if (err_acc == FE_OK) cur_err = fill_err_e'(fetch_error);
    end

    llm_sync_fifo #(
        .WIDTH (CHI_ADDR_WIDTH),
        .DEPTH (TAG_DEPTH)
    ) u_addr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (clk_en),
        .push      (fifo_push),
        .push_data (alloc_addr),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            beat_cnt        <= '0;
            err_acc         <= FE_OK;
            line_q          <= '0;
            fetch_ready     <= 1'b0;
            arr_wr_valid    <= 1'b0;
            arr_wr_addr     <= '0;
            fill_done_valid <= 1'b0;
            fill_done_addr  <= '0;
            fill_done_error <= FE_OK;
            fill_cnt        <= '0;
            fill_err_cnt    <= '0;
        end else if (clk_en) begin
            fill_done_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state       <= ST_COLLECT;
                        fetch_ready <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (fetch_valid) begin
                        line_q[beat_cnt] <= fetch_data;
                        err_acc          <= cur_err;
                        if (beat_cnt != LAST_BEAT) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end else begin
                            fetch_ready <= 1'b0;
                            if (cur_err == FE_OK) begin
                                state        <= ST_WRITE;
                                arr_wr_valid <= 1'b1;
                                arr_wr_addr  <= fifo_head;
                            end else begin
                                state           <= ST_DONE;
                                fill_done_valid <= 1'b1;
                                fill_done_addr  <= fifo_head;
                                fill_done_error <= cur_err;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (arr_wr_ready) begin
                        state           <= ST_DONE;
                        arr_wr_valid    <= 1'b0;
                        fill_done_valid <= 1'b1;
                        fill_done_addr  <= fifo_head;
                        fill_done_error <= err_acc;
                    end
                end
                ST_DONE: begin
                    beat_cnt <= '0;
                    err_acc  <= FE_OK;
                    if (err_acc == FE_OK) fill_cnt     <= sat_inc(fill_cnt);
                    else                  fill_err_cnt <= sat_inc(fill_err_cnt);
                    if (fifo_left) begin
                        state       <= ST_COLLECT;
                        fetch_ready <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
